// File: rtl/v_result_writeback.sv
// Vector result writeback: buffers one ALU or MUL result group from the lane
// array and writes it to the vector register file one register per cycle.
module v_result_writeback #(
    parameter int VLEN    = 128,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sel_mul,
    input  logic [2:0]         lmul,
    input  logic [RADDR_W-1:0] vd,
    input  logic [VLEN-1:0]    result_valu_1,
    input  logic [VLEN-1:0]    result_valu_2,
    input  logic [VLEN-1:0]    result_valu_3,
    input  logic [VLEN-1:0]    result_valu_4,
    input  logic [VLEN-1:0]    result_vmul_1,
    input  logic [VLEN-1:0]    result_vmul_2,
    input  logic [VLEN-1:0]    result_vmul_3,
    input  logic [VLEN-1:0]    result_vmul_4,
    output logic               wr_en,
    output logic [RADDR_W-1:0] wr_addr,
    output logic [VLEN-1:0]    wr_data,
    input  logic               wr_ready,
    output logic               busy,
    output logic               wb_done,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [1:0]           last_q, last_d;
    logic [RADDR_W-1:0]   vd_q, vd_d;
    logic [VLEN-1:0]      slice_q [4];
    logic [VLEN-1:0]      slice_d [4];
    logic                 err_q, err_d;

    logic [1:0]           grp_last;
    logic                 grp_bad;

    // N-1 for the group size; alignment means the low bits of vd under this mask are zero.
    always_comb begin
        grp_last = 2'd0;
        grp_bad  = 1'b0;
        case (lmul)
            3'd0:    grp_last = 2'd0;
            3'd1:    grp_last = 2'd1;
            3'd2:    grp_last = 2'd3;
            default: grp_bad  = 1'b1;
        endcase
        if ((vd[1:0] & grp_last) != 2'd0) begin
            grp_bad = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        vd_d    = vd_q;
        slice_d = slice_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (grp_bad) begin
                        err_d = 1'b1;
                    end else begin
                        vd_d       = vd;
                        last_d     = grp_last;
                        idx_d      = 2'd0;
                        slice_d[0] = sel_mul ? result_vmul_1 : result_valu_1;
                        slice_d[1] = sel_mul ? result_vmul_2 : result_valu_2;
                        slice_d[2] = sel_mul ? result_vmul_3 : result_valu_3;
                        slice_d[3] = sel_mul ? result_vmul_4 : result_valu_4;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if (idx_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the slice buffer is a small register array, so it is cleared on reset
    // like the rest of the state; sequential state always uses non-blocking assignment.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            vd_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slice_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            vd_q    <= vd_d;
            err_q   <= err_d;
            slice_q <= slice_d;
        end
    end

    // Address and data are forced to zero whenever no write is requested.
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign wr_en    = (state_q == WRITE);
    assign wr_addr  = wr_en ? (vd_q + RADDR_W'(idx_q)) : '0;
    assign wr_data  = wr_en ? slice_q[idx_q] : '0;
    assign wb_done  = (state_q == DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_v_result_writeback.sv
// Directed self-checking bench for v_result_writeback with hand-computed
// expected register-file writes.
module tb_v_result_writeback;

    localparam int VLEN    = 128;
    localparam int RADDR_W = 5;

    logic               clk;
    logic               nrst;
    logic               in_valid;
    logic               in_ready;
    logic               sel_mul;
    logic [2:0]         lmul;
    logic [RADDR_W-1:0] vd;
    logic [VLEN-1:0]    result_valu_1, result_valu_2, result_valu_3, result_valu_4;
    logic [VLEN-1:0]    result_vmul_1, result_vmul_2, result_vmul_3, result_vmul_4;
    logic               wr_en;
    logic [RADDR_W-1:0] wr_addr;
    logic [VLEN-1:0]    wr_data;
    logic               wr_ready;
    logic               busy;
    logic               wb_done;
    logic               err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    localparam logic [VLEN-1:0] PAT_A5 = {16{8'hA5}};

    v_result_writeback #(.VLEN(VLEN), .RADDR_W(RADDR_W)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sel_mul       (sel_mul),
        .lmul          (lmul),
        .vd            (vd),
        .result_valu_1 (result_valu_1),
        .result_valu_2 (result_valu_2),
        .result_valu_3 (result_valu_3),
        .result_valu_4 (result_valu_4),
        .result_vmul_1 (result_vmul_1),
        .result_vmul_2 (result_vmul_2),
        .result_vmul_3 (result_vmul_3),
        .result_vmul_4 (result_vmul_4),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .busy          (busy),
        .wb_done       (wb_done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted register-file writes, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en && wr_ready) n_writes++;
    end

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one group for a single edge; caller must be in IDLE.
    task automatic present(input logic s, input logic [2:0] l, input logic [RADDR_W-1:0] v,
                           input logic [VLEN-1:0] alu_base, input logic [VLEN-1:0] mul_base);
        sel_mul       = s;
        lmul          = l;
        vd            = v;
        result_valu_1 = alu_base;
        result_valu_2 = alu_base + 1;
        result_valu_3 = alu_base + 2;
        result_valu_4 = alu_base + 3;
        result_vmul_1 = mul_base;
        result_vmul_2 = mul_base + 1;
        result_vmul_3 = mul_base + 2;
        result_vmul_4 = mul_base + 3;
        in_valid      = 1'b1;
        check("ready_before_accept", in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        int wr_snap;
        nrst     = 1'b0;
        in_valid = 1'b0;
        wr_ready = 1'b1;
        present_defaults();
        #12;
        check("rst_wr_en",   wr_en, 0);
        check("rst_busy",    busy, 0);
        check("rst_wb_done", wb_done, 0);
        check("rst_err",     err, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        #10;
        nrst = 1'b1;
        next_cycle();
        check("post_rst_ready", in_ready, 1);

        // Single register, ALU path.
        present(1'b0, 3'd0, 5'd7, PAT_A5, 128'hDEAD);
        check("t1_wr_en",  wr_en, 1);
        check("t1_addr",   wr_addr, 7);
        check("t1_data",   wr_data, PAT_A5);
        check("t1_busy",   busy, 1);
        check("t1_ready",  in_ready, 0);
        next_cycle();
        check("t1_done",   wb_done, 1);
        check("t1_wr_off", wr_en, 0);
        check("t1_data0",  wr_data, 0);
        next_cycle();
        check("t1_done_clr", wb_done, 0);
        check("t1_idle",     busy, 0);

        // Four registers, MUL path.
        present(1'b1, 3'd2, 5'd8, 128'h5555, 128'd1);
        for (int k = 0; k < 4; k++) begin
            check("t2_wr_en", wr_en, 1);
            check("t2_addr",  wr_addr, VLEN'(8 + k));
            check("t2_data",  wr_data, VLEN'(k + 1));
            check("t2_ready", in_ready, 0);
            next_cycle();
        end
        check("t2_done",  wb_done, 1);
        check("t2_ready_done", in_ready, 0);
        next_cycle();
        check("t2_idle",  in_ready, 1);

        // Backpressure on the first write of a two-register group.
        wr_ready = 1'b0;
        wr_snap  = n_writes;
        present(1'b0, 3'd1, 5'd4, 128'h1000, 128'h2000);
        for (int i = 0; i < 4; i++) begin
            wr_ready = (i == 3);
            check("t3_hold_addr", wr_addr, 4);
            check("t3_hold_data", wr_data, 128'h1000);
            next_cycle();
        end
        check("t3_addr2", wr_addr, 5);
        check("t3_data2", wr_data, 128'h1001);
        next_cycle();
        check("t3_done",   wb_done, 1);
        check("t3_nwrite", VLEN'(n_writes - wr_snap), 2);
        next_cycle();

        // Misaligned base and reserved lmul are rejected.
        present(1'b0, 3'd2, 5'd6, 128'h1, 128'h2);
        check("t4a_err",   err, 1);
        check("t4a_wr_en", wr_en, 0);
        check("t4a_ready", in_ready, 1);
        check("t4a_busy",  busy, 0);
        next_cycle();
        check("t4a_err_clr", err, 0);
        check("t4a_no_done", wb_done, 0);
        present(1'b1, 3'd3, 5'd0, 128'h1, 128'h2);
        check("t4b_err",   err, 1);
        check("t4b_wr_en", wr_en, 0);
        check("t4b_ready", in_ready, 1);
        next_cycle();
        check("t4b_err_clr", err, 0);
        check("t4b_no_done", wb_done, 0);

        // Inputs changing mid-group must not disturb the captured group.
        present(1'b1, 3'd2, 5'd0, 128'h7000, 128'hC0DE_0000);
        vd            = 5'd20;
        sel_mul       = 1'b0;
        lmul          = 3'd0;
        result_vmul_2 = '1;
        result_vmul_3 = '1;
        result_vmul_4 = '1;
        for (int k = 0; k < 4; k++) begin
            check("t5_addr", wr_addr, VLEN'(k));
            check("t5_data", wr_data, 128'hC0DE_0000 + VLEN'(k));
            next_cycle();
        end
        check("t5_done", wb_done, 1);
        next_cycle();

        // Reset in the middle of a group aborts it.
        present(1'b1, 3'd2, 5'd12, 128'h0, 128'h9900);
        next_cycle();
        next_cycle();
        check("t6_addr_pre", wr_addr, 14);
        nrst = 1'b0;
        #1;
        check("t6_wr_en",  wr_en, 0);
        check("t6_busy",   busy, 0);
        check("t6_data",   wr_data, 0);
        check("t6_no_done", wb_done, 0);
        @(negedge clk);
        nrst = 1'b1;
        next_cycle();
        check("t6_ready",  in_ready, 1);
        check("t6_no_done2", wb_done, 0);
        present(1'b0, 3'd0, 5'd3, 128'hBEEF, 128'h0);
        check("t6_new_addr", wr_addr, 3);
        check("t6_new_data", wr_data, 128'hBEEF);
        next_cycle();
        check("t6_new_done", wb_done, 1);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    task automatic present_defaults();
        sel_mul       = 1'b0;
        lmul          = 3'd0;
        vd            = '0;
        result_valu_1 = '0;
        result_valu_2 = '0;
        result_valu_3 = '0;
        result_valu_4 = '0;
        result_vmul_1 = '0;
        result_vmul_2 = '0;
        result_vmul_3 = '0;
        result_vmul_4 = '0;
    endtask

endmodule
